// File: rtl/fifo_skid_storage.sv
// In-order skid store: register array with wrapping pointers and an occupancy counter.
// Head is combinational; a pop on empty is ignored, a push into a full store without a pop is dropped.
module fifo_skid_storage #(
  parameter int unsigned Width     = 16,
  parameter int unsigned DepthLog2 = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [Width-1:0]     push_data_i,
  input  logic                 pop_i,
  output logic [Width-1:0]     head_o,
  output logic [DepthLog2:0]   occupancy_o,
  output logic [DepthLog2:0]   occupancy_next_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam logic [DepthLog2:0] DepthCount = (DepthLog2 + 1)'(Depth);

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DepthLog2:0]   occ_q, occ_d;
  logic                 push_ok, pop_ok;

  assign empty_o          = (occ_q == '0);
  assign full_o           = (occ_q == DepthCount);
  assign head_o           = mem_q[rd_ptr_q];
  assign occupancy_o      = occ_q;
  assign occupancy_next_o = occ_d;

  always_comb begin
    pop_ok   = pop_i && !empty_o;
    // A same-cycle pop frees the slot, so a full store can still accept.
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) begin
      occ_d = occ_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fifo_write_side_skid.sv
// Write-side adapter for a FIFO: bypasses producer words when the store is empty, otherwise
// drains the skid store in order, and throttles the producer ahead of almostFull.
module fifo_write_side_skid #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned SKID_DEPTH_LOG2 = 2,
  parameter int unsigned STALL_LATENCY   = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       dataInValid,
  input  logic [WIDTH-1:0]           dataIn,
  output logic                       slowDown,
  input  logic                       fifoAlmostFull,
  output logic                       fifoWriteEnable,
  output logic [WIDTH-1:0]           fifoDataIn,
  output logic [SKID_DEPTH_LOG2:0]   skidOccupancy,
  output logic                       overflowError
);

  localparam int unsigned SkidDepth  = 1 << SKID_DEPTH_LOG2;
  localparam int unsigned SlowThresh = SkidDepth - STALL_LATENCY;

  logic                     skid_push, skid_pop, skid_full, skid_empty;
  logic [WIDTH-1:0]         skid_head;
  logic [SKID_DEPTH_LOG2:0] occ_next;
  logic                     emit, drop;

  logic             we_q, we_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             slow_q, slow_d;
  logic             ovf_q, ovf_d;

  fifo_skid_storage #(
    .Width     (WIDTH),
    .DepthLog2 (SKID_DEPTH_LOG2)
  ) u_storage (
    .clk_i            (clk),
    .rst_ni           (rstn),
    .push_i           (skid_push),
    .push_data_i      (dataIn),
    .pop_i            (skid_pop),
    .head_o           (skid_head),
    .occupancy_o      (skidOccupancy),
    .occupancy_next_o (occ_next),
    .full_o           (skid_full),
    .empty_o          (skid_empty)
  );

  always_comb begin
    // DRAIN mode whenever the store holds anything; incoming words queue behind the head.
    skid_pop  = !fifoAlmostFull && !skid_empty;
    skid_push = dataInValid && (fifoAlmostFull || !skid_empty);
    emit      = !fifoAlmostFull && (dataInValid || !skid_empty);
    drop      = skid_push && skid_full && !skid_pop;

    we_d   = emit;
    data_d = skid_empty ? dataIn : skid_head;
    slow_d = fifoAlmostFull || (32'(occ_next) >= SlowThresh);
    ovf_d  = ovf_q || drop;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      we_q   <= 1'b0;
      data_q <= '0;
      slow_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      data_q <= data_d;
      slow_q <= slow_d;
      ovf_q  <= ovf_d;
    end
  end

  assign fifoWriteEnable = we_q;
  assign fifoDataIn      = data_q;
  assign slowDown        = slow_q;
  assign overflowError   = ovf_q;

endmodule

// File: tb/tb_fifo_write_side_skid.sv
// Directed bench for fifo_write_side_skid: bypass, stall/drain, overflow, full push+pop, reset.
module tb_fifo_write_side_skid;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dataInValid;
  logic [15:0] dataIn;
  logic        slowDown;
  logic        fifoAlmostFull;
  logic        fifoWriteEnable;
  logic [15:0] fifoDataIn;
  logic [2:0]  skidOccupancy;
  logic        overflowError;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_write_side_skid #(
    .WIDTH           (16),
    .SKID_DEPTH_LOG2 (2),
    .STALL_LATENCY   (2)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .dataInValid     (dataInValid),
    .dataIn          (dataIn),
    .slowDown        (slowDown),
    .fifoAlmostFull  (fifoAlmostFull),
    .fifoWriteEnable (fifoWriteEnable),
    .fifoDataIn      (fifoDataIn),
    .skidOccupancy   (skidOccupancy),
    .overflowError   (overflowError)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; dataInValid = 1'b0; dataIn = '0; fifoAlmostFull = 1'b0;
    cycle(); cycle();
    n_checks++; if (fifoWriteEnable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", fifoWriteEnable); end
    n_checks++; if (skidOccupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", skidOccupancy); end
    n_checks++; if (slowDown !== 1'b1) begin n_fail++; $display("FAIL reset_slow got %b want 1", slowDown); end
    n_checks++; if (overflowError !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflowError); end
    rstn = 1'b1;
    cycle();
    n_checks++; if (slowDown !== 1'b0) begin n_fail++; $display("FAIL release_slow got %b want 0", slowDown); end
    n_checks++; if (fifoWriteEnable !== 1'b0) begin n_fail++; $display("FAIL release_we got %b want 0", fifoWriteEnable); end
    n_checks++; if (skidOccupancy !== 3'd0) begin n_fail++; $display("FAIL release_occ got %0d want 0", skidOccupancy); end
  endtask

  task automatic test_bypass();
    fifoAlmostFull = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dataInValid = 1'b1; dataIn = 16'(i + 1);
      cycle();
      n_checks++; if (fifoWriteEnable !== 1'b1) begin n_fail++; $display("FAIL bypass_we[%0d] got %b want 1", i, fifoWriteEnable); end
      n_checks++; if (fifoDataIn !== 16'(i + 1)) begin n_fail++; $display("FAIL bypass_data[%0d] got %h want %h", i, fifoDataIn, 16'(i + 1)); end
      n_checks++; if (skidOccupancy !== 3'd0) begin n_fail++; $display("FAIL bypass_occ[%0d] got %0d want 0", i, skidOccupancy); end
    end
    dataInValid = 1'b0;
    cycle();
    n_checks++; if (fifoWriteEnable !== 1'b0) begin n_fail++; $display("FAIL bypass_idle_we got %b want 0", fifoWriteEnable); end
  endtask

  task automatic test_stall_drain();
    logic        in_af  [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic        in_v   [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [15:0] in_d   [7] = '{16'h0100, 16'h0101, 16'h0102, 0, 0, 0, 0};
    logic        ex_we  [7] = '{0, 0, 0, 1, 1, 1, 0};
    logic [15:0] ex_d   [7] = '{0, 0, 0, 16'h0100, 16'h0101, 16'h0102, 0};
    logic [2:0]  ex_occ [7] = '{1, 2, 3, 2, 1, 0, 0};
    logic        ex_sd  [7] = '{1, 1, 1, 1, 0, 0, 0};
    logic [2:0]  peak = '0;
    for (int k = 0; k < 7; k++) begin
      fifoAlmostFull = in_af[k]; dataInValid = in_v[k]; dataIn = in_d[k];
      cycle();
      if (skidOccupancy > peak) peak = skidOccupancy;
      n_checks++; if (fifoWriteEnable !== ex_we[k]) begin n_fail++; $display("FAIL stall_we[%0d] got %b want %b", k, fifoWriteEnable, ex_we[k]); end
      n_checks++; if (skidOccupancy !== ex_occ[k]) begin n_fail++; $display("FAIL stall_occ[%0d] got %0d want %0d", k, skidOccupancy, ex_occ[k]); end
      n_checks++; if (slowDown !== ex_sd[k]) begin n_fail++; $display("FAIL stall_slow[%0d] got %b want %b", k, slowDown, ex_sd[k]); end
      if (ex_we[k]) begin
        n_checks++; if (fifoDataIn !== ex_d[k]) begin n_fail++; $display("FAIL stall_data[%0d] got %h want %h", k, fifoDataIn, ex_d[k]); end
      end
    end
    n_checks++; if (peak !== 3'd3) begin n_fail++; $display("FAIL stall_peak got %0d want 3", peak); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) begin
      fifoAlmostFull = 1'b1; dataInValid = 1'b1; dataIn = 16'h0200 + 16'(k);
      cycle();
      n_checks++; if (fifoWriteEnable !== 1'b0) begin n_fail++; $display("FAIL ovf_we[%0d] got %b want 0", k, fifoWriteEnable); end
      n_checks++; if (skidOccupancy !== 3'((k < 4) ? k + 1 : 4)) begin n_fail++; $display("FAIL ovf_occ[%0d] got %0d want %0d", k, skidOccupancy, (k < 4) ? k + 1 : 4); end
      n_checks++; if (overflowError !== (k == 4)) begin n_fail++; $display("FAIL ovf_flag[%0d] got %b want %b", k, overflowError, k == 4); end
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] ex_d   [5] = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0205};
    logic [2:0]  ex_occ [5] = '{4, 3, 2, 1, 0};
    for (int k = 0; k < 5; k++) begin
      fifoAlmostFull = 1'b0; dataInValid = (k == 0); dataIn = (k == 0) ? 16'h0205 : 16'h0;
      cycle();
      n_checks++; if (fifoWriteEnable !== 1'b1) begin n_fail++; $display("FAIL pp_we[%0d] got %b want 1", k, fifoWriteEnable); end
      n_checks++; if (fifoDataIn !== ex_d[k]) begin n_fail++; $display("FAIL pp_data[%0d] got %h want %h", k, fifoDataIn, ex_d[k]); end
      n_checks++; if (skidOccupancy !== ex_occ[k]) begin n_fail++; $display("FAIL pp_occ[%0d] got %0d want %0d", k, skidOccupancy, ex_occ[k]); end
    end
    dataInValid = 1'b0;
    cycle();
    n_checks++; if (fifoWriteEnable !== 1'b0) begin n_fail++; $display("FAIL pp_idle_we got %b want 0", fifoWriteEnable); end
    n_checks++; if (overflowError !== 1'b1) begin n_fail++; $display("FAIL pp_ovf_sticky got %b want 1", overflowError); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      fifoAlmostFull = 1'b1; dataInValid = 1'b1; dataIn = 16'h0300 + 16'(k);
      cycle();
    end
    n_checks++; if (skidOccupancy !== 3'd3) begin n_fail++; $display("FAIL mid_held_occ got %0d want 3", skidOccupancy); end
    rstn = 1'b0; fifoAlmostFull = 1'b0; dataInValid = 1'b0; dataIn = '0;
    cycle();
    n_checks++; if (skidOccupancy !== 3'd0) begin n_fail++; $display("FAIL mid_rst_occ got %0d want 0", skidOccupancy); end
    n_checks++; if (fifoWriteEnable !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we got %b want 0", fifoWriteEnable); end
    n_checks++; if (overflowError !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got %b want 0", overflowError); end
    n_checks++; if (slowDown !== 1'b1) begin n_fail++; $display("FAIL mid_rst_slow got %b want 1", slowDown); end
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_checks++; if (fifoWriteEnable !== 1'b0) begin n_fail++; $display("FAIL mid_post_we[%0d] got %b want 0", k, fifoWriteEnable); end
      n_checks++; if (skidOccupancy !== 3'd0) begin n_fail++; $display("FAIL mid_post_occ[%0d] got %0d want 0", k, skidOccupancy); end
    end
    n_checks++; if (slowDown !== 1'b0) begin n_fail++; $display("FAIL mid_post_slow got %b want 0", slowDown); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_stall_drain();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
